// File: rtl/console_keys.sv
// Console key debouncer and command sequencer: one command per debounced press.
// Optional auto-repeat of the held key is compiled in with `define CONSOLE_REPEAT_EN.
module console_keys #(
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned REPEAT_TICKS   = 25
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scan_tick,
    input  logic [9:0] keys,
    input  logic       rept_sw,
    output logic [9:0] keys_db,
    output logic       cmd_valid,
    output logic [3:0] cmd_code,
    input  logic       cmd_ready
);

    localparam logic [3:0] DB_LIMIT = DEBOUNCE_TICKS[3:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_HELD = 2'd2
    } state_t;

    // Lowest set bit of a 10-bit vector; callers guarantee at least one bit is set.
    function automatic logic [3:0] f_lowest(input logic [9:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            idx = v[i] ? 4'(i) : idx;
        end
        return idx;
    endfunction

    logic [3:0] r_cnt [10];
    logic [9:0] r_keys_db;
    logic [9:0] r_db_d;
    logic [9:0] w_press;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_sel;
    logic [3:0] w_sel_nxt;
    logic       r_cmd_valid;
    logic       w_valid_nxt;
    logic [3:0] r_cmd_code;
    logic [3:0] w_code_nxt;

`ifdef CONSOLE_REPEAT_EN
    localparam logic [7:0] RPT_LIMIT = REPEAT_TICKS[7:0];
    logic [7:0] r_rpt_cnt;
    logic [7:0] w_rpt_nxt;
`else
    logic w_unused_rept;
    assign w_unused_rept = rept_sw;
`endif

    // Per-key debounce: the level flips only after DEBOUNCE_TICKS consecutive disagreeing scans.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 10; i++) begin
                r_cnt[i] <= 4'd0;
            end
            r_keys_db <= 10'd0;
        end else if (scan_tick) begin
            for (int i = 0; i < 10; i++) begin
                if (keys[i] == r_keys_db[i]) begin
                    r_cnt[i] <= 4'd0;
                end else if (r_cnt[i] + 4'd1 == DB_LIMIT) begin
                    r_keys_db[i] <= ~r_keys_db[i];
                    r_cnt[i]     <= 4'd0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 4'd1;
                end
            end
        end else begin
            r_keys_db <= r_keys_db;
        end
    end

    // Previous debounced level, so a rise is seen as a press for exactly one clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_db_d <= 10'd0;
        end else begin
            r_db_d <= r_keys_db;
        end
    end

    assign w_press = r_keys_db & ~r_db_d;

    // Sequencer state and registered command outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_sel       <= 4'd0;
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= 4'd0;
`ifdef CONSOLE_REPEAT_EN
            r_rpt_cnt   <= 8'd0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_cmd_valid <= w_valid_nxt;
            r_cmd_code  <= w_code_nxt;
`ifdef CONSOLE_REPEAT_EN
            r_rpt_cnt   <= w_rpt_nxt;
`endif
        end
    end

    // Next-state and next-output logic for the command handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_valid_nxt = r_cmd_valid;
        w_code_nxt  = r_cmd_code;
`ifdef CONSOLE_REPEAT_EN
        w_rpt_nxt   = r_rpt_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (|w_press) begin
                    w_sel_nxt   = f_lowest(w_press);
                    w_code_nxt  = f_lowest(w_press) + 4'd1;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_PEND;
                end else begin
                    w_valid_nxt = 1'b0;
                    w_code_nxt  = 4'd0;
                end
            end
            ST_PEND: begin
                // Releasing the key does not retract an offered command.
                if (r_cmd_valid && cmd_ready) begin
                    w_valid_nxt = 1'b0;
                    w_code_nxt  = 4'd0;
                    w_state_nxt = ST_HELD;
`ifdef CONSOLE_REPEAT_EN
                    w_rpt_nxt   = 8'd0;
`endif
                end else begin
                    w_state_nxt = ST_PEND;
                end
            end
            ST_HELD: begin
                w_valid_nxt = 1'b0;
                w_code_nxt  = 4'd0;
                if (scan_tick && (r_keys_db == 10'd0)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
`ifdef CONSOLE_REPEAT_EN
                    if (!rept_sw) begin
                        w_rpt_nxt = 8'd0;
                    end else if (scan_tick && r_keys_db[r_sel]) begin
                        if (r_rpt_cnt + 8'd1 == RPT_LIMIT) begin
                            w_rpt_nxt   = 8'd0;
                            w_valid_nxt = 1'b1;
                            w_code_nxt  = r_sel + 4'd1;
                            w_state_nxt = ST_PEND;
                        end else begin
                            w_rpt_nxt = r_rpt_cnt + 8'd1;
                        end
                    end else begin
                        w_rpt_nxt = r_rpt_cnt;
                    end
`else
                    w_state_nxt = ST_HELD;
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
                w_code_nxt  = 4'd0;
            end
        endcase
    end

    assign keys_db   = r_keys_db;
    assign cmd_valid = r_cmd_valid;
    assign cmd_code  = r_cmd_code;

endmodule

// File: tb/tb_console_keys.sv
// Directed bench for console_keys: debounce, single-command handshake, reset, repeat.
module tb_console_keys;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       scan_tick;
    logic [9:0] keys;
    logic       rept_sw;
    logic [9:0] keys_db;
    logic       cmd_valid;
    logic [3:0] cmd_code;
    logic       cmd_ready;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [15:0] xfer_cnt = 16'd0;
    logic [3:0]  last_code = 4'd0;

    console_keys #(.DEBOUNCE_TICKS(4), .REPEAT_TICKS(25)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .scan_tick (scan_tick),
        .keys      (keys),
        .rept_sw   (rept_sw),
        .keys_db   (keys_db),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_ready (cmd_ready)
    );

    always #5 clk = ~clk;

    // Record every completed transfer independently of the DUT's internal state.
    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) begin
            xfer_cnt  <= xfer_cnt + 16'd1;
            last_code <= cmd_code;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scan_n(input int n);
        for (int k = 0; k < n; k++) begin
            scan_tick = 1'b1;
            step();
            scan_tick = 1'b0;
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        scan_tick = 1'b0;
        keys      = 10'd0;
        rept_sw   = 1'b0;
        cmd_ready = 1'b1;
        #12;
        chk("reset_db",    16'(keys_db),   16'd0);
        chk("reset_valid", 16'(cmd_valid), 16'd0);
        chk("reset_code",  16'(cmd_code),  16'd0);
        reset_n = 1'b1;
        step();

        // Key 1 held: level rises on the 4th scan, command one clk later.
        keys = 10'b00_0000_0010;
        scan_n(3);
        chk("db_after3", 16'(keys_db), 16'd0);
        scan_n(1);
        chk("db_after4",   16'(keys_db),   16'h002);
        chk("valid_lat0",  16'(cmd_valid), 16'd0);
        step();
        chk("k1_valid", 16'(cmd_valid), 16'd1);
        chk("k1_code",  16'(cmd_code),  16'd2);
        step();
        chk("k1_valid_drop", 16'(cmd_valid), 16'd0);
        chk("k1_code_drop",  16'(cmd_code),  16'd0);
        chk("k1_xfer",       xfer_cnt,       16'd1);
        chk("k1_last",       16'(last_code), 16'd2);
        scan_n(20);
        chk("k1_no_second", xfer_cnt, 16'd1);
        keys = 10'd0;
        scan_n(5);
        chk("k1_release_db", 16'(keys_db), 16'd0);

        // Key 6 glitches: 3 high, 1 low, 3 high, then low; never debounces.
        keys = 10'b00_0100_0000;
        scan_n(3);
        keys = 10'd0;
        scan_n(1);
        keys = 10'b00_0100_0000;
        scan_n(3);
        chk("glitch_db", 16'(keys_db), 16'd0);
        keys = 10'd0;
        scan_n(4);
        chk("glitch_db2",   16'(keys_db),   16'd0);
        chk("glitch_valid", 16'(cmd_valid), 16'd0);
        chk("glitch_xfer",  xfer_cnt,       16'd1);

        // Keys 3 and 8 debounce together: only key 3 is issued.
        keys = 10'b01_0000_1000;
        scan_n(4);
        chk("dual_db", 16'(keys_db), 16'h108);
        step();
        chk("dual_code", 16'(cmd_code), 16'd4);
        step();
        chk("dual_xfer", xfer_cnt,       16'd2);
        chk("dual_last", 16'(last_code), 16'd4);
        keys = 10'b01_0000_0000;
        scan_n(6);
        chk("dual_k8_ignored", xfer_cnt, 16'd2);
        keys = 10'd0;
        scan_n(5);
        keys = 10'b01_0000_0000;
        scan_n(4);
        step();
        chk("k8_code", 16'(cmd_code), 16'd9);
        step();
        chk("k8_xfer", xfer_cnt, 16'd3);
        keys = 10'd0;
        scan_n(5);

        // Key 7 offered with ready low for 10 clk while the key is released.
        cmd_ready = 1'b0;
        keys = 10'b00_1000_0000;
        scan_n(4);
        step();
        chk("k7_valid", 16'(cmd_valid), 16'd1);
        keys = 10'd0;
        for (int i = 0; i < 10; i++) begin
            scan_tick = (i < 4) ? 1'b1 : 1'b0;
            step();
            scan_tick = 1'b0;
            chk("k7_hold_valid", 16'(cmd_valid), 16'd1);
            chk("k7_hold_code",  16'(cmd_code),  16'd8);
        end
        chk("k7_released_db", 16'(keys_db), 16'd0);
        cmd_ready = 1'b1;
        step();
        chk("k7_xfer",  xfer_cnt,        16'd4);
        chk("k7_last",  16'(last_code),  16'd8);
        chk("k7_valid0", 16'(cmd_valid), 16'd0);
        scan_n(1);

        // Reset during PEND drops the command; a fresh debounce is required.
        cmd_ready = 1'b0;
        keys = 10'b00_0000_0001;
        scan_n(4);
        step();
        chk("k0_valid", 16'(cmd_valid), 16'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_valid", 16'(cmd_valid), 16'd0);
        chk("rst_code",  16'(cmd_code),  16'd0);
        chk("rst_db",    16'(keys_db),   16'd0);
        #2;
        reset_n = 1'b1;
        cmd_ready = 1'b1;
        step();
        step();
        chk("rst_no_reissue", 16'(cmd_valid), 16'd0);
        scan_n(3);
        chk("rst_db3",    16'(keys_db),   16'd0);
        chk("rst_valid3", 16'(cmd_valid), 16'd0);
        scan_n(1);
        step();
        chk("rst_fresh_code", 16'(cmd_code), 16'd1);
        step();
        chk("rst_xfer", xfer_cnt, 16'd5);
        keys = 10'd0;
        scan_n(5);

`ifdef CONSOLE_REPEAT_EN
        // Auto-repeat of key 7 every 25 scans while REPT is on.
        rept_sw = 1'b1;
        keys = 10'b00_1000_0000;
        scan_n(4);
        step();
        chk("rpt_first_code", 16'(cmd_code), 16'd8);
        step();
        chk("rpt_first_xfer", xfer_cnt, 16'd6);
        scan_n(24);
        chk("rpt_not_yet", 16'(cmd_valid), 16'd0);
        scan_n(1);
        chk("rpt1_valid", 16'(cmd_valid), 16'd1);
        chk("rpt1_code",  16'(cmd_code),  16'd8);
        step();
        chk("rpt1_xfer", xfer_cnt, 16'd7);
        scan_n(25);
        chk("rpt2_valid", 16'(cmd_valid), 16'd1);
        step();
        chk("rpt2_xfer", xfer_cnt, 16'd8);
        rept_sw = 1'b0;
        scan_n(60);
        chk("rpt_stopped", xfer_cnt, 16'd8);
        keys = 10'd0;
        scan_n(5);
`else
        // REPT switch has no effect without the repeat feature.
        rept_sw = 1'b1;
        keys = 10'b00_0000_0100;
        scan_n(4);
        step();
        chk("norpt_code", 16'(cmd_code), 16'd3);
        step();
        chk("norpt_xfer", xfer_cnt, 16'd6);
        scan_n(60);
        chk("norpt_none", xfer_cnt, 16'd6);
        keys = 10'd0;
        scan_n(5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/console_keys.md
CONSOLE_KEYS -- requirements
Module: console_keys

Interface
REQ-001 Parameter: DEBOUNCE_TICKS, 4, consecutive scan_tick samples needed to change a debounced key level (range 1..15).
REQ-002 Parameter: REPEAT_TICKS, 25, scan_tick count between auto-repeated commands (range 1..255).
REQ-003 Port: clk  input  1  single block clock; all state on its rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: scan_tick  input  1  one-clk strobe from the console scanner when a full row sweep has completed and keys are valid.
REQ-006 Port: keys  input  10  raw momentary keys from the scanner. Bit order: [0] read_in, [1] start, [2] cont, [3] stop, [4] reset_switch, [5] xct, [6] examine_this, [7] examine_next, [8] deposit_this, [9] deposit_next.
REQ-007 Port: rept_sw  input  1  console REPT toggle switch level.
REQ-008 Port: keys_db  output  10  debounced key levels.
REQ-009 Port: cmd_valid  output  1  console command offered to the CPU.
REQ-010 Port: cmd_code  output  4  command = key index + 1 (1..10); 0 when no command is offered.
REQ-011 Port: cmd_ready  input  1  CPU accepts the command; transfer occurs on a clk edge where cmd_valid && cmd_ready.

Function
REQ-012 Debounce: one 4-bit counter per key; the counter updates only on scan_tick.
REQ-013 On scan_tick, when keys[i] == keys_db[i], counter i clears to 0.
REQ-014 On scan_tick, when keys[i] != keys_db[i], counter i increments.
REQ-015 When counter i reaches DEBOUNCE_TICKS, keys_db[i] toggles and counter i clears in the same edge.
REQ-016 Press event: a 0->1 transition of keys_db[i] is a press event, usable on the following clk only.
REQ-017 FSM states: IDLE, PEND, HELD.
REQ-018 IDLE: on any press event, select the lowest index i among the new presses, latch sel=i, drive cmd_code=i+1 and cmd_valid=1, and go to PEND.
REQ-019 PEND: cmd_valid and cmd_code stay stable until transfer; releasing the key does not retract the command.
REQ-020 PEND, on transfer: go to HELD, and drive cmd_valid=0 and cmd_code=0 from the next clk.
REQ-021 HELD: any further press events are ignored; no new command is issued until all keys_db are 0.
REQ-022 HELD: when keys_db == 0 is sampled, return to IDLE.
REQ-023 Simultaneous press events on one edge: exactly one command is issued, the lowest index; the other presses are dropped.
REQ-024 Latency: cmd_valid asserts exactly one clk after the edge where keys_db[i] rises.

Reset
REQ-025 While reset_n=0, asynchronously: FSM=IDLE; all counters=0; keys_db=0; cmd_valid=0; cmd_code=0; repeat counter=0.
REQ-026 A reset during PEND drops the pending command immediately; it is not reissued after reset.
REQ-027 After reset_n deasserts, a key still held needs DEBOUNCE_TICKS scan_ticks before it produces a new press event.

Configuration
REQ-028 The macro CONSOLE_REPEAT_EN compiles in the auto-repeat feature.
REQ-029 With CONSOLE_REPEAT_EN, in HELD with rept_sw=1 and keys_db[sel]=1: a repeat counter increments on each scan_tick.
REQ-030 With CONSOLE_REPEAT_EN, when the repeat counter reaches REPEAT_TICKS, it clears, cmd_code=sel+1 and cmd_valid=1, and the FSM goes to PEND.
REQ-031 With CONSOLE_REPEAT_EN, the repeat counter clears on entry to HELD and whenever rept_sw=0.
REQ-032 Without CONSOLE_REPEAT_EN, rept_sw is ignored, no repeat counter exists, and HELD exits only on all-released.

Verification
REQ-033 Scenario: keys[1] held 4 scan_ticks, cmd_ready=1 -> keys_db[1]=1 after the 4th tick; one-clk cmd_valid with cmd_code=2; no second command while held.
REQ-034 Scenario: keys[6] glitches high for 3 scan_ticks then low (DEBOUNCE_TICKS=4) -> keys_db stays 0 and no command issues.
REQ-035 Scenario: keys[3] and keys[8] reach debounce on the same tick -> single command with cmd_code=4; nothing for key 8 until all keys are released and key 8 is pressed again.
REQ-036 Scenario: cmd_ready=0 for 10 clk while key 7 is released -> cmd_valid/cmd_code=8 held stable for 10 clk; transfer on the 11th clk; then return to IDLE on the next scan_tick.
REQ-037 Scenario: reset_n pulsed low during PEND -> cmd_valid=0 within the same cycle; no command after release of reset_n until a fresh debounced press.
REQ-038 Scenario (CONSOLE_REPEAT_EN, REPEAT_TICKS=25, rept_sw=1): keys[7] held 100 scan_ticks -> first command code 8, then repeats at 25-tick spacing; clearing rept_sw stops the repeats.
